// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
//  Package : fc_pkg
//  Shared types and helpers for the fully-connected layer output path.
//  Revision: 1.0  initial release
// ============================================================================
package fc_pkg;

    // Serializer control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } fc_ser_state_t;

    // Width of a full-precision FC accumulator: product width plus growth over the fan-in
    function automatic int z_width(input int width, input int fan_in);
        return 2 * width + $clog2(fan_in);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_requant_sat.sv
`default_nettype none
// ============================================================================
//  Module  : fc_requant_sat
//  Combinational requantizer: signed Z_W-bit accumulator -> unsigned WIDTH-bit
//  activation. Negative inputs clamp to zero, positive inputs are shifted
//  right by SHIFT with round-half-up and saturate at 2^WIDTH-1.
//  Revision: 1.0  initial release
// ============================================================================
module fc_requant_sat #(
    parameter int Z_W   = 25,
    parameter int WIDTH = 8,
    parameter int SHIFT = 8
) (
    input  logic signed [Z_W-1:0] v,
    output logic [WIDTH-1:0]      r
);
    // Half an output LSB; a zero shift needs no rounding term
    localparam int             RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [Z_W:0]   RND     = (SHIFT > 0) ? ((Z_W + 1)'(1) << RND_POS) : '0;

    logic [Z_W:0] sum;
    logic [Z_W:0] shifted;

    // One extra bit of headroom keeps the rounding add from wrapping
    always_comb begin
        sum     = {1'b0, v} + RND;
        shifted = sum >> SHIFT;
        if (v[Z_W-1]) begin
            r = '0;
        end else if (|shifted[Z_W:WIDTH]) begin
            r = '1;
        end else begin
            r = shifted[WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fc_out_serializer.sv
`default_nettype none
// ============================================================================
//  Module  : fc_out_serializer
//  Captures one parallel vector of FC results, requantizes each element and
//  streams them one per beat with index and last flag.
//  Optional macro FC_SER_PINGPONG_EN adds a shadow buffer so a new vector can
//  be captured while the current one streams, giving gap-free output.
//  Revision: 1.0  initial release
// ============================================================================
module fc_out_serializer
    import fc_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int IN    = 400,
    parameter  int N_OUT = 120,
    parameter  int SHIFT = 8,
    localparam int Z_W   = z_width(WIDTH, IN),
    localparam int IDW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [Z_W-1:0] in_z [0:N_OUT-1],
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDW-1:0]        out_idx,
    output logic                  out_last,
    output logic                  busy
);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(N_OUT - 1);
    localparam logic           ONE_BEAT = (N_OUT == 1);

    fc_ser_state_t         state;
    logic [IDW-1:0]        idx;
    logic [IDW-1:0]        next_idx;
    logic [IDW-1:0]        rd_idx;
    logic signed [Z_W-1:0] vec_buf [0:N_OUT-1];
    logic signed [Z_W-1:0] rd_val;
    logic [WIDTH-1:0]      rq_val;
    logic                  capture;
    logic                  beat_accept;
    logic                  promote;
`ifdef FC_SER_PINGPONG_EN
    logic signed [Z_W-1:0] shadow [0:N_OUT-1];
    logic                  sh_full;
`endif

    assign capture     = in_valid && in_ready;
    assign beat_accept = out_valid && out_ready;
    assign next_idx    = idx + 1'b1;
    // Keep the read index in range on the last beat (value unused there)
    assign rd_idx      = (idx == LAST_IDX) ? '0 : next_idx;

`ifdef FC_SER_PINGPONG_EN
    assign in_ready = !sh_full;
    assign busy     = (state != IDLE) || sh_full;
    assign promote  = (state == STREAM) && beat_accept && out_last && sh_full;
`else
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign promote  = 1'b0;
`endif

    // Select the word feeding the requantizer: head on LOAD, next word while streaming, shadow head on promotion
    always_comb begin
        rd_val = vec_buf[0];
        if (state == STREAM) begin
            rd_val = vec_buf[rd_idx];
        end
`ifdef FC_SER_PINGPONG_EN
        if (promote) begin
            rd_val = shadow[0];
        end
`endif
    end

    fc_requant_sat #(
        .Z_W   (Z_W),
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_rq (
        .v (rd_val),
        .r (rq_val)
    );

    // Vector storage; contents are don't-care after reset so no reset branch
    always_ff @(posedge clk) begin
`ifdef FC_SER_PINGPONG_EN
        if (capture && (state == IDLE)) begin
            vec_buf <= in_z;
        end else if (promote || ((state == IDLE) && sh_full)) begin
            vec_buf <= shadow;
        end
        if (capture && (state != IDLE)) begin
            shadow <= in_z;
        end
`else
        if (capture) begin
            vec_buf <= in_z;
        end
`endif
    end

    // Control FSM and output beat registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
`ifdef FC_SER_PINGPONG_EN
            sh_full   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        idx   <= '0;
                        state <= LOAD;
                    end
`ifdef FC_SER_PINGPONG_EN
                    else if (sh_full) begin
                        idx   <= '0;
                        state <= LOAD;
                    end
`endif
                end
                LOAD: begin
                    out_data  <= rq_val;
                    out_idx   <= '0;
                    out_valid <= 1'b1;
                    out_last  <= ONE_BEAT;
                    state     <= STREAM;
                end
                STREAM: begin
                    if (beat_accept) begin
                        if (!out_last) begin
                            idx      <= next_idx;
                            out_data <= rq_val;
                            out_idx  <= next_idx;
                            out_last <= (next_idx == LAST_IDX);
                        end else if (promote) begin
                            // Shadow vector takes over on the same edge: no bubble
                            idx      <= '0;
                            out_data <= rq_val;
                            out_idx  <= '0;
                            out_last <= ONE_BEAT;
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef FC_SER_PINGPONG_EN
            if (capture && (state != IDLE)) begin
                sh_full <= 1'b1;
            end else if (promote || ((state == IDLE) && sh_full)) begin
                sh_full <= 1'b0;
            end
`endif
        end
    end

endmodule
`default_nettype wire
